// File: rtl/wb_lsu_master_if.sv
// CPU load/store request/response channel plus Wishbone pipelined master bus, bundled as one port.
// Signal names keep the i_/o_ prefixes as seen from the master, so each modport mirrors the other.
interface wb_lsu_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [31:0]           i_req_wdata;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic                  o_rsp_valid;
    logic [31:0]           o_rsp_rdata;
    logic                  o_rsp_err;
    logic                  o_wb_cyc;
    logic                  o_wb_stb;
    logic                  o_wb_we;
    logic [ADDR_WIDTH-1:0] o_wb_addr;
    logic [31:0]           o_wb_data;
    logic [3:0]            o_wb_sel;
    logic                  i_wb_ack;
    logic                  i_wb_stall;
    logic [31:0]           i_wb_data;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_ack, i_wb_stall, i_wb_data
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_ack, i_wb_stall, i_wb_data
    );
endinterface

// File: rtl/wb_lsu_master.sv
// Single-outstanding load/store to Wishbone pipelined master with lane steering and load extension.
// Latency: 3 cycles accept-to-response with a 1-cycle-ack slave, +1 per stall cycle; errors respond 1 cycle after accept.
// Backpressure: o_req_ready only in IDLE; i_wb_stall holds stb; missing ack aborts after TIMEOUT_CYCLES.
module wb_lsu_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    wb_lsu_master_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic                  uns_q, uns_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  bad_req;
    logic [3:0]            req_sel;
    logic [31:0]           req_wdat;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_ext;

    // Request decode: lane enables, replicated store data and alignment check.
    always_comb begin
        bad_req  = 1'b0;
        req_sel  = 4'b1111;
        req_wdat = bus.i_req_wdata;
        case (bus.i_req_size)
            2'b00: begin
                req_sel  = 4'b0001 << bus.i_req_addr[1:0];
                req_wdat = {4{bus.i_req_wdata[7:0]}};
            end
            2'b01: begin
                req_sel  = bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdat = {2{bus.i_req_wdata[15:0]}};
                bad_req  = bus.i_req_addr[0];
            end
            2'b10: begin
                bad_req  = (bus.i_req_addr[1:0] != 2'b00);
            end
            default: begin
                bad_req  = 1'b1;
            end
        endcase
        if (!bus.i_req_we) begin
            req_wdat = 32'h0;
        end
    end

    // Load extraction uses the lane captured with the request, not the live bus address.
    always_comb begin
        ld_byte = bus.i_wb_data[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? bus.i_wb_data[31:16] : bus.i_wb_data[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = bus.i_wb_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdat_d      = wdat_q;
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid) begin
                    we_d   = bus.i_req_we;
                    addr_d = {bus.i_req_addr[ADDR_WIDTH-1:2], 2'b00};
                    sel_d  = req_sel;
                    wdat_d = req_wdat;
                    size_d = bus.i_req_size;
                    lane_d = bus.i_req_addr[1:0];
                    uns_d  = bus.i_req_unsigned;
                    cnt_d  = '0;
                    if (bad_req) begin
                        state_d     = S_RESP;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final counted cycle still completes the access normally.
                if (bus.i_wb_ack) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = we_q ? 32'h0 : ld_ext;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                end else if (state_q == S_REQ && !bus.i_wb_stall) begin
                    state_d     = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cyc_d     = (state_d == S_REQ) || (state_d == S_WAIT);
        stb_d     = (state_d == S_REQ);
        rsp_vld_d = (state_d == S_RESP);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            sel_q       <= 4'h0;
            wdat_q      <= 32'h0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            uns_q       <= 1'b0;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdat_q      <= wdat_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.o_req_ready = (state_q == S_IDLE) && !i_reset;
    assign bus.o_rsp_valid = rsp_vld_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = stb_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_addr   = addr_q;
    assign bus.o_wb_sel    = sel_q;
    assign bus.o_wb_data   = wdat_q;
endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed plus random load/store traffic against a byte-array memory model and a stalling/acking slave.
// Checks latency, lane steering, extension, error responses, timeout and asynchronous reset.
module tb_wb_lsu_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_lsu_master_if #(.ADDR_WIDTH(32)) bus ();

    wb_lsu_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int rsp_pulses = 0;

    logic [31:0] slv_mem [64];
    logic [7:0]  ref_b   [256];

    int   stall_left = 0;
    bit   ack_en     = 1'b1;
    bit   pend       = 1'b0;
    logic [31:0] pend_dat;
    logic [5:0]  idx;

    int          r_lat, r_cyc_hi, r_stb_hi, r_acc;
    logic [31:0] r_rd, r_addr, r_dat;
    logic [3:0]  r_sel;
    logic        r_err;
    bit          r_cyc_seen, r_unstable;

    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (bus.o_rsp_valid) rsp_pulses++;

    // Slave: stalls while stall_left > 0, otherwise accepts the strobe and acks the following cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            bus.i_wb_ack   = 1'b0;
            bus.i_wb_stall = 1'b0;
        end else begin
            bus.i_wb_ack  = pend && ack_en;
            bus.i_wb_data = pend ? pend_dat : 32'hDEADBEEF;
            pend = 1'b0;
            if (bus.o_wb_cyc && bus.o_wb_stb) begin
                if (stall_left > 0) begin
                    bus.i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    bus.i_wb_stall = 1'b0;
                    pend = 1'b1;
                    idx  = bus.o_wb_addr[7:2];
                    if (bus.o_wb_we)
                        for (int l = 0; l < 4; l++)
                            if (bus.o_wb_sel[l]) slv_mem[idx][8*l +: 8] = bus.o_wb_data[8*l +: 8];
                    pend_dat = slv_mem[idx];
                end
            end else begin
                bus.i_wb_stall = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int b;
        logic [15:0] h;
        b = int'(a & 32'hFF);
        h = {ref_b[(b + 1) % 256], ref_b[b]};
        case (sz)
            2'd0:    return uns ? 32'(ref_b[b]) : 32'(int'($signed(ref_b[b])));
            2'd1:    return uns ? 32'(h) : 32'(int'($signed(h)));
            default: return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int b;
        int n;
        b = int'(a & 32'hFF);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_b[b + k] = wd[8*k +: 8];
    endtask

    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit uns);
        int  guard;
        bit  first;
        bus.i_req_valid = 1'b1;  bus.i_req_we = we;   bus.i_req_addr = a;
        bus.i_req_wdata = wd;    bus.i_req_size = sz; bus.i_req_unsigned = uns;
        guard = 0;
        while (!bus.o_req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        r_acc = cyc_n;
        bus.i_req_valid = 1'b0;
        r_lat = 1; r_cyc_seen = 0; r_unstable = 0; r_cyc_hi = 0; r_stb_hi = 0; first = 1;
        r_addr = 0; r_sel = 0; r_dat = 0;
        while (!bus.o_rsp_valid && r_lat < 100) begin
            if (bus.o_wb_cyc) begin
                r_cyc_seen = 1; r_cyc_hi++;
                if (first) begin
                    r_addr = bus.o_wb_addr; r_sel = bus.o_wb_sel; r_dat = bus.o_wb_data; first = 0;
                end else if (r_addr !== bus.o_wb_addr || r_sel !== bus.o_wb_sel || r_dat !== bus.o_wb_data) begin
                    r_unstable = 1;
                end
            end
            if (bus.o_wb_stb) r_stb_hi++;
            @(posedge clk); #1;
            r_lat++;
        end
        r_rd  = bus.o_rsp_rdata;
        r_err = bus.o_rsp_err;
        @(posedge clk); #1;
        chk("rsp_one_cycle", 32'(bus.o_rsp_valid), 32'd0);
    endtask

    task automatic txn(input string tag, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns, input int stall);
        bit          bad;
        logic [31:0] exp_rd, exp_dat;
        logic [3:0]  exp_sel;
        bad     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        exp_rd  = (bad || we) ? 32'h0 : ref_load(a, sz, uns);
        exp_sel = (sz == 2'd0) ? 4'b0001 << a[1:0] : (sz == 2'd1) ? 4'b0011 << (a[1:0] & 2'b10) : 4'hF;
        exp_dat = !we ? 32'h0 : (sz == 2'd0) ? 32'(wd[7:0]) * 32'h01010101
                : (sz == 2'd1) ? 32'(wd[15:0]) * 32'h00010001 : wd;
        stall_left = stall;
        do_req(we, a, wd, sz, uns);
        stall_left = 0;
        chk({tag, "_lat"},   32'(r_lat), bad ? 32'd1 : 32'(3 + stall));
        chk({tag, "_err"},   32'(r_err), 32'(bad));
        chk({tag, "_rdata"}, r_rd, exp_rd);
        chk({tag, "_cyc"},   32'(r_cyc_seen), 32'(!bad));
        if (!bad) begin
            chk({tag, "_addr"},   r_addr, a & ~32'h3);
            chk({tag, "_sel"},    32'(r_sel), 32'(exp_sel));
            chk({tag, "_wbdat"},  r_dat, exp_dat);
            chk({tag, "_stable"}, 32'(r_unstable), 32'd0);
            chk({tag, "_stb"},    32'(r_stb_hi), 32'(1 + stall));
            if (we) ref_store(a, wd, sz);
        end
    endtask

    initial begin
        int a0, pulses0;
        logic [31:0] w;
        rst = 1'b1;
        bus.i_req_valid = 0; bus.i_req_we = 0; bus.i_req_addr = 0; bus.i_req_wdata = 0;
        bus.i_req_size = 0; bus.i_req_unsigned = 0;
        bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_wb_data = 0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (i == 4) w = 32'h80FF7F01;
            slv_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[8*k +: 8];
        end
        #12;
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_cyc",   32'(bus.o_wb_cyc),    32'd0);
        chk("rst_stb",   32'(bus.o_wb_stb),    32'd0);
        chk("rst_rsp",   32'(bus.o_rsp_valid), 32'd0);
        chk("rst_rdata", bus.o_rsp_rdata,      32'h0);
        chk("rst_err",   32'(bus.o_rsp_err),   32'd0);
        chk("rst_sel",   32'(bus.o_wb_sel),    32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_idle", 32'(bus.o_req_ready), 32'd1);

        txn("lb12",  0, 32'h12, 0, 2'd0, 0, 0);
        chk("lb12_val", r_rd, 32'hFFFFFFFF);
        chk("lb12_sel", 32'(r_sel), 32'h4);
        txn("lbu13", 0, 32'h13, 0, 2'd0, 1, 0);
        chk("lbu13_val", r_rd, 32'h00000080);
        txn("lh12",  0, 32'h12, 0, 2'd1, 0, 0);
        chk("lh12_val", r_rd, 32'hFFFF80FF);
        txn("lhu10", 0, 32'h10, 0, 2'd1, 1, 0);
        chk("lhu10_val", r_rd, 32'h00007F01);

        txn("sb11", 1, 32'h11, 32'h000000A5, 2'd0, 0, 0);
        chk("sb11_sel", 32'(r_sel), 32'h2);
        chk("sb11_dat", r_dat, 32'hA5A5A5A5);
        chk("sb11_adr", r_addr, 32'h10);
        txn("sw10", 1, 32'h10, 32'h12345678, 2'd2, 0, 0);
        a0 = r_acc;
        txn("lw10", 0, 32'h10, 0, 2'd2, 0, 0);
        chk("lw10_val", r_rd, 32'h12345678);
        chk("b2b_interval", 32'(r_acc - a0), 32'd4);

        txn("lw06", 0, 32'h06, 0, 2'd2, 0, 0);
        txn("lw10_stall", 0, 32'h10, 0, 2'd2, 0, 3);
        chk("stall_val", r_rd, 32'h12345678);

        ack_en = 1'b0;
        do_req(0, 32'h20, 0, 2'd2, 0);
        chk("tmo_cyc_hi", 32'(r_cyc_hi), 32'd16);
        chk("tmo_lat",    32'(r_lat),    32'd17);
        chk("tmo_err",    32'(r_err),    32'd1);
        chk("tmo_rdata",  r_rd,          32'h0);
        ack_en = 1'b1;
        txn("after_tmo", 0, 32'h20, 0, 2'd2, 0, 0);

        ack_en = 1'b0;
        pulses0 = rsp_pulses;
        bus.i_req_valid = 1; bus.i_req_we = 0; bus.i_req_addr = 32'h24; bus.i_req_size = 2'd2;
        @(posedge clk); #1; bus.i_req_valid = 0;
        @(posedge clk); #1;
        chk("wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
        chk("wait_stb", 32'(bus.o_wb_stb), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc",   32'(bus.o_wb_cyc),    32'd0);
        chk("arst_stb",   32'(bus.o_wb_stb),    32'd0);
        chk("arst_ready", 32'(bus.o_req_ready), 32'd0);
        @(posedge clk); #1; rst = 1'b0; ack_en = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready_after", 32'(bus.o_req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_rsp", 32'(rsp_pulses - pulses0), 32'd0);
        txn("after_rst", 0, 32'h24, 0, 2'd2, 0, 0);

        for (int n = 0; n < 40; n++) begin
            txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 64; i += 8) begin
            txn($sformatf("final_lw%0d", i), 0, 32'(4 * i), 0, 2'd2, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
